hid_report_mux: RTL and testbench

Multi-channel HID report capture and display composer between N `usbh_host_hid` instances and the `hex_decoder_v` data input. It replaces the single-port `R_display` latch, so all USB ports can run at once instead of one being chosen at compile time. Per channel it provides:

- report latching
- change detection
- staleness (unplug) detection
- report counters

A mode input selects whether the display shows all channels packed, one fixed channel, or an automatic scan across active channels.

---
 rtl/hid_pkg.sv | 10 +
 rtl/hid_channel_slot.sv | 48 ++++
 rtl/hid_report_mux.sv | 99 +++++++++
 tb/tb_hid_report_mux.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hid_pkg.sv
// hid_pkg: shared mode encodings, scan states and report width helper for hid_report_mux
package hid_pkg;
  localparam logic [1:0] MODE_PACK = 2'd0;
  localparam logic [1:0] MODE_FIXED = 2'd1;
  localparam logic [1:0] MODE_SCAN = 2'd2;
  typedef enum logic {HOLD, SEEK} scan_state_t;
  function automatic int report_width(input int bytes);
    return bytes * 8;
  endfunction
endpackage

// File: rtl/hid_channel_slot.sv
// hid_channel_slot: per-channel report latch, change detect, report count and stale timer (HID_REPORT_MUX_DIFF_EN)
module hid_channel_slot #(
  parameter int W = 64,
  parameter int C_stale_cycles = 6000000,
  parameter int C_clear_stale = 1
) (
  input logic clk,
  input logic rst,
  input logic [W-1:0] report,
  input logic valid,
  output logic [W-1:0] slot,
  output logic [7:0] cnt,
  output logic changed,
  output logic active
);
  localparam int TW = $clog2(C_stale_cycles + 1);
  logic [TW-1:0] timer;
  logic diff, upd, stale;
`ifdef HID_REPORT_MUX_DIFF_EN
  assign diff = report != slot;
  assign upd = valid && diff;
`else
  assign diff = 1'b0;
  assign upd = valid;
`endif
  assign stale = !valid && timer == TW'(C_stale_cycles - 1);
  // latch/count on accepted reports; the saturating timer ages the channel out unless a valid refreshes it
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      cnt <= '0;
      changed <= 1'b0;
      active <= 1'b0;
      timer <= '0;
    end else begin
      changed <= valid && diff;
      if (upd) begin
        slot <= report;
        cnt <= cnt + 8'd1;
      end else if (stale && C_clear_stale != 0) slot <= '0;
      if (valid) begin
        timer <= '0;
        active <= 1'b1;
      end else if (timer != TW'(C_stale_cycles)) timer <= timer + TW'(1);
      if (stale) active <= 1'b0;
    end
  end
endmodule

// File: rtl/hid_report_mux.sv
// hid_report_mux: multi-channel HID report capture and display composer (HID_REPORT_MUX_DIFF_EN enables change detection)
module hid_report_mux
  import hid_pkg::*;
#(
  parameter int C_channels = 2,
  parameter int C_report_bytes = 8,
  parameter int C_disp_bits = 256,
  parameter int C_stale_cycles = 6000000,
  parameter int C_clear_stale = 1,
  parameter int C_scan_cycles = 12000000,
  localparam int W = report_width(C_report_bytes),
  localparam int CW = C_channels > 1 ? $clog2(C_channels) : 1
) (
  input logic clk,
  input logic bus_reset,
  input logic [C_channels*W-1:0] hid_report,
  input logic [C_channels-1:0] hid_valid,
  input logic [1:0] mode,
  input logic [CW-1:0] sel,
  output logic [C_disp_bits-1:0] display,
  output logic [C_channels-1:0] changed,
  output logic [C_channels-1:0] active,
  output logic [CW-1:0] cur_ch,
  output logic [7:0] led
);
  localparam int SW = C_scan_cycles > 1 ? $clog2(C_scan_cycles) : 1;
  logic [W-1:0] slot [C_channels];
  logic [7:0] cnt [C_channels];
  logic [C_channels*W-1:0] packed_slots;
  scan_state_t state, state_n;
  logic [SW-1:0] dwell, dwell_n;
  logic [3:0] steps, steps_n;
  logic [CW-1:0] cur_n, nxt;
  logic [1:0] mode_q;
  logic cur_ok;
  logic [W-1:0] cur_slot;
  logic [7:0] cur_cnt;
  for (genvar g = 0; g < C_channels; g++) begin : g_ch
    hid_channel_slot #(
      .W(W),
      .C_stale_cycles(C_stale_cycles),
      .C_clear_stale(C_clear_stale)
    ) u_slot (
      .clk(clk),
      .rst(bus_reset),
      .report(hid_report[g*W +: W]),
      .valid(hid_valid[g]),
      .slot(slot[g]),
      .cnt(cnt[g]),
      .changed(changed[g]),
      .active(active[g])
    );
    assign packed_slots[g*W +: W] = slot[g];
  end
  assign cur_ok = 32'(cur_ch) < C_channels;
  assign cur_slot = cur_ok ? slot[cur_ch] : '0;
  assign cur_cnt = cur_ok ? cnt[cur_ch] : '0;
  assign led = {4'(active), cur_cnt[3:0]};
  // scan FSM next state: runs only in scan mode, fixed mode tracks sel, pack mode parks on channel 0
  always_comb begin
    nxt = 32'(cur_ch) >= C_channels - 1 ? '0 : cur_ch + CW'(1);
    state_n = HOLD;
    dwell_n = '0;
    steps_n = '0;
    cur_n = '0;
    if (mode == MODE_FIXED) cur_n = sel;
    else if (mode == MODE_SCAN) begin
      cur_n = cur_ch;
      if (state == HOLD) begin
        state_n = dwell == SW'(C_scan_cycles - 1) ? SEEK : HOLD;
        dwell_n = dwell == SW'(C_scan_cycles - 1) ? '0 : dwell + SW'(1);
      end else begin
        cur_n = !active[nxt] && steps == 4'(C_channels - 1) ? '0 : nxt;
        state_n = active[nxt] || steps == 4'(C_channels - 1) ? HOLD : SEEK;
        steps_n = state_n == SEEK ? steps + 4'd1 : '0;
      end
    end
  end
  // state registers and display composition from the registered mode, channel and slots
  always_ff @(posedge clk) begin
    if (bus_reset) begin
      state <= HOLD;
      dwell <= '0;
      steps <= '0;
      cur_ch <= '0;
      mode_q <= MODE_PACK;
      display <= '0;
    end else begin
      state <= state_n;
      dwell <= dwell_n;
      steps <= steps_n;
      cur_ch <= cur_n;
      mode_q <= mode;
      display <= mode_q == MODE_FIXED || mode_q == MODE_SCAN
        ? C_disp_bits'({cur_cnt, 5'b0, 3'(cur_ch), cur_slot})
        : C_disp_bits'(packed_slots);
    end
  end
endmodule

// File: tb/tb_hid_report_mux.sv
// tb_hid_report_mux: table-driven and sequence checks for hid_report_mux (honours HID_REPORT_MUX_DIFF_EN)
module tb_hid_report_mux;
  logic clk = 1'b0;
  logic bus_reset;
  logic [255:0] hid_report;
  logic [3:0] hid_valid;
  logic [1:0] mode;
  logic [1:0] sel;
  logic [255:0] display;
  logic [3:0] changed;
  logic [3:0] active;
  logic [1:0] cur_ch;
  logic [7:0] led;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [1:0] mode; logic [1:0] sel; logic [3:0] v; logic [255:0] rep;} vec_t;
  typedef struct {logic [255:0] disp; logic [3:0] chg; logic [7:0] led; logic [1:0] cur;} exp_t;
  typedef struct {int ch; int len;} run_t;
  vec_t vt [8];
  exp_t sb [$];
  run_t runs [$];
  logic [63:0] mslot [4];
  logic [7:0] mcnt [4];
  logic [3:0] mact;
`ifdef HID_REPORT_MUX_DIFF_EN
  localparam logic [255:0] DUP_CNT = 256'd1;
`else
  localparam logic [255:0] DUP_CNT = 256'd2;
`endif
  hid_report_mux #(
    .C_channels(4),
    .C_report_bytes(8),
    .C_disp_bits(256),
    .C_stale_cycles(100),
    .C_clear_stale(1),
    .C_scan_cycles(10)
  ) dut (
    .clk(clk),
    .bus_reset(bus_reset),
    .hid_report(hid_report),
    .hid_valid(hid_valid),
    .mode(mode),
    .sel(sel),
    .display(display),
    .changed(changed),
    .active(active),
    .cur_ch(cur_ch),
    .led(led)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [255:0] exp_disp(input logic [1:0] m, input logic [1:0] s);
    logic [255:0] d;
    d = '0;
    if (m == 2'd1) begin
      d[63:0] = mslot[s];
      d[79:64] = {mcnt[s], 5'b0, 1'b0, s};
    end else d = {mslot[3], mslot[2], mslot[1], mslot[0]};
    return d;
  endfunction
  task automatic apply(input vec_t t);
    exp_t e;
    logic [63:0] r;
    logic [1:0] cur;
    hid_report = t.rep;
    hid_valid = t.v;
    mode = t.mode;
    sel = t.sel;
    e.chg = '0;
    for (int k = 0; k < 4; k++) begin
      if (t.v[k]) begin
        r = t.rep[k*64 +: 64];
`ifdef HID_REPORT_MUX_DIFF_EN
        e.chg[k] = r != mslot[k];
        if (r != mslot[k]) begin
          mslot[k] = r;
          mcnt[k] = mcnt[k] + 8'd1;
        end
`else
        mslot[k] = r;
        mcnt[k] = mcnt[k] + 8'd1;
`endif
        mact[k] = 1'b1;
      end
    end
    cur = t.mode == 2'd1 ? t.sel : 2'd0;
    e.cur = cur;
    e.disp = exp_disp(t.mode, t.sel);
    e.led = {mact, mcnt[cur][3:0]};
    sb.push_back(e);
    tick();
    hid_valid = '0;
    chk("changed", 256'(changed), 256'(sb[0].chg));
    chk("cur_ch", 256'(cur_ch), 256'(sb[0].cur));
    tick();
    e = sb.pop_front();
    chk("display", display, e.disp);
    chk("led", 256'(led), 256'(e.led));
  endtask
  task automatic wait_cur(input logic [1:0] c, input int budget);
    int n;
    n = 0;
    while (cur_ch !== c && n < budget) begin
      tick();
      n++;
    end
    chk("wait_cur", 256'(cur_ch), 256'(c));
  endtask
  task automatic observe(input int n);
    int prev;
    int len;
    bit partial;
    prev = -1;
    len = 0;
    partial = 1'b1;
    runs.delete();
    for (int i = 0; i < n; i++) begin
      tick();
      if (int'(cur_ch) == prev) len++;
      else begin
        if (!partial && len >= 5) runs.push_back('{prev, len});
        if (prev >= 0) partial = 1'b0;
        prev = int'(cur_ch);
        len = 1;
      end
    end
  endtask
  initial begin
    bus_reset = 1'b1;
    hid_valid = '0;
    hid_report = '0;
    mode = 2'd0;
    sel = 2'd0;
    mact = '0;
    for (int k = 0; k < 4; k++) begin
      mslot[k] = '0;
      mcnt[k] = '0;
    end
    vt[0] = '{2'd0, 2'd0, 4'b0011, {64'h0, 64'h0, 64'h22, 64'h11}};
    vt[1] = '{2'd0, 2'd0, 4'b0001, {192'h0, 64'h11}};
    vt[2] = '{2'd3, 2'd0, 4'b0100, {64'h0, 64'hDEAD_BEEF_0123_4567, 128'h0}};
    vt[3] = '{2'd0, 2'd0, 4'b1000, 256'h0};
    vt[4] = '{2'd1, 2'd2, 4'b1111, {64'hD4, 64'hC3C3_C3C3_C3C3_C3C3, 64'hB2, 64'hA1}};
    vt[5] = '{2'd1, 2'd1, 4'b0010, {128'h0, 64'hB2, 64'h0}};
    vt[6] = '{2'd1, 2'd3, 4'b0000, 256'h0};
    vt[7] = '{2'd0, 2'd0, 4'b0000, 256'h0};
    tick();
    tick();
    chk("rst_display", display, '0);
    chk("rst_changed", 256'(changed), '0);
    chk("rst_active", 256'(active), '0);
    chk("rst_cur_ch", 256'(cur_ch), '0);
    chk("rst_led", 256'(led), '0);
    bus_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply(vt[i]);
      if (i == 1) chk("dup_cnt0", 256'(led[3:0]), DUP_CNT);
    end
    bus_reset = 1'b1;
    tick();
    bus_reset = 1'b0;
    mode = 2'd0;
    hid_report = '0;
    hid_report[127:64] = 64'h5A5A;
    hid_valid = 4'b0010;
    tick();
    hid_valid = '0;
    repeat (99) tick();
    chk("active1_at99", 256'(active[1]), 256'(1'b1));
    chk("slot1_at99", 256'(display[127:64]), 256'(64'h5A5A));
    tick();
    chk("active1_at100", 256'(active[1]), 256'(1'b0));
    chk("slot1_at100", 256'(display[127:64]), 256'(64'h5A5A));
    tick();
    chk("slot1_cleared", 256'(display[127:64]), '0);
    hid_report[63:0] = 64'h77;
    hid_valid = 4'b0001;
    tick();
    hid_valid = '0;
    repeat (99) tick();
    hid_valid = 4'b0001;
    tick();
    hid_valid = '0;
    chk("active0_tie", 256'(active[0]), 256'(1'b1));
    tick();
    chk("slot0_tie", 256'(display[63:0]), 256'(64'h77));
    bus_reset = 1'b1;
    tick();
    bus_reset = 1'b0;
    mode = 2'd2;
    hid_report = '0;
    hid_report[127:64] = 64'h1;
    hid_valid = 4'b0010;
    tick();
    hid_valid = '0;
    wait_cur(2'd1, 40);
    observe(60);
    chk("scan1_runs", 256'(runs.size() >= 2), 256'(1'b1));
    foreach (runs[i]) begin
      chk("scan1_ch", 256'(runs[i].ch), 256'd1);
      chk("scan1_len", 256'(runs[i].len), 256'd11);
    end
    hid_report[255:192] = 64'h3;
    hid_valid = 4'b1010;
    tick();
    hid_valid = '0;
    observe(80);
    chk("scan2_runs", 256'(runs.size() >= 2), 256'(1'b1));
    foreach (runs[i]) begin
      if (i == 0) chk("scan2_first", 256'(runs[i].ch == 1 || runs[i].ch == 3), 256'(1'b1));
      else chk("scan2_alt", 256'(runs[i].ch), 256'(4 - runs[i-1].ch));
      chk("scan2_len", 256'(runs[i].len), 256'd11);
    end
    hid_report = {4{64'hFFFF}};
    hid_valid = 4'b1111;
    bus_reset = 1'b1;
    tick();
    hid_valid = '0;
    chk("mid_rst_display", display, '0);
    chk("mid_rst_changed", 256'(changed), '0);
    chk("mid_rst_active", 256'(active), '0);
    chk("mid_rst_cur_ch", 256'(cur_ch), '0);
    chk("mid_rst_led", 256'(led), '0);
    bus_reset = 1'b0;
    mode = 2'd0;
    tick();
    tick();
    chk("rst_valid_dropped", display, '0);
    chk("rst_valid_inactive", 256'(active), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
